// File: rtl/prbs15_checker.sv
// prbs15_checker: self-synchronising PRBS-15 (x^15+x^14+1) byte checker with lock FSM and saturating bit-error counter
module prbs15_checker #(
   parameter int LOCK_CNT = 4,
   parameter int ERR_THR  = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       data_in,
   input  logic             data_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_byte,
   output logic [3:0]       err_bits,
   output logic             sync_loss,
   output logic [CNT_W-1:0] bit_err_cnt
);
   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
   localparam logic [3:0] LC = 4'(LOCK_CNT);
   localparam logic [3:0] ET = 4'(ERR_THR);
   state_t           r_state, w_state;
   logic [14:0]      r_s, w_s, w_run, w_seed;
   logic [7:0]       w_pred, w_diff;
   logic [3:0]       r_match_cnt, w_match_cnt, r_consec_err, w_consec_err, w_pop, w_err_bits;
   logic             r_seed_cnt, w_seed_cnt, w_err_byte, w_sync_loss;
   logic [CNT_W:0]   w_sum;
   logic [CNT_W-1:0] w_cnt;
   // eight free-running LFSR steps give the predicted byte, MSB first
   always_comb begin
      w_run  = r_s;
      w_pred = '0;
      w_pop  = '0;
      for (int i = 7; i >= 0; i--) begin
         w_run     = {w_run[13:0], w_run[14] ^ w_run[13]};
         w_pred[i] = w_run[0];
      end
      w_diff = data_in ^ w_pred;
      for (int i = 0; i < 8; i++) w_pop = w_pop + {3'b0, w_diff[i]};
   end
   assign w_seed = {r_s[6:0], data_in};
   always_comb begin
      w_state      = r_state;
      w_s          = r_s;
      w_seed_cnt   = r_seed_cnt;
      w_match_cnt  = r_match_cnt;
      w_consec_err = r_consec_err;
      w_err_byte   = 1'b0;
      w_err_bits   = '0;
      w_sync_loss  = 1'b0;
      if (data_valid) begin
         case (r_state)
            SEARCH: begin
               w_s        = w_seed;
               w_seed_cnt = ~r_seed_cnt;
               if (r_seed_cnt && w_seed != '0) begin
                  w_state     = VERIFY;
                  w_match_cnt = '0;
               end
            end
            VERIFY: begin
               w_s = w_run;
               if (w_diff == '0) begin
                  w_match_cnt = r_match_cnt + 4'd1;
                  if (r_match_cnt == LC - 4'd1) begin
                     w_state      = LOCKED;
                     w_consec_err = '0;
                  end
               end else begin
                  w_state     = SEARCH;
                  w_seed_cnt  = 1'b0;
                  w_match_cnt = '0;
               end
            end
            LOCKED: begin
               w_s          = w_run;
               w_consec_err = '0;
               if (w_diff != '0) begin
                  w_err_byte   = 1'b1;
                  w_err_bits   = w_pop;
                  w_consec_err = r_consec_err + 4'd1;
                  if (r_consec_err == ET - 4'd1) begin
                     w_sync_loss  = 1'b1;
                     w_state      = SEARCH;
                     w_seed_cnt   = 1'b0;
                     w_match_cnt  = '0;
                     w_consec_err = '0;
                  end
               end
            end
            default: w_state = SEARCH;
         endcase
      end
   end
   // w_err_bits is zero unless a locked byte is errored, so the add is otherwise a hold
   assign w_sum = {1'b0, bit_err_cnt} + {{(CNT_W-3){1'b0}}, w_err_bits};
   assign w_cnt = clr_cnt ? '0 : w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= SEARCH;
         r_s          <= '0;
         r_seed_cnt   <= 1'b0;
         r_match_cnt  <= '0;
         r_consec_err <= '0;
         locked       <= 1'b0;
         err_byte     <= 1'b0;
         err_bits     <= '0;
         sync_loss    <= 1'b0;
         bit_err_cnt  <= '0;
      end else begin
         r_state      <= w_state;
         r_s          <= w_s;
         r_seed_cnt   <= w_seed_cnt;
         r_match_cnt  <= w_match_cnt;
         r_consec_err <= w_consec_err;
         locked       <= w_state == LOCKED;
         err_byte     <= w_err_byte;
         err_bits     <= w_err_bits;
         sync_loss    <= w_sync_loss;
         bit_err_cnt  <= w_cnt;
      end
   end
endmodule

// File: doc/prbs15_checker.md
# prbs15_checker

Receive-side companion to the PRBS-15 byte generator. It consumes the 8-bit-per-cycle PRBS-15 stream (x^15 + x^14 + 1), self-synchronises its own LFSR from the incoming data, verifies lock, and then counts bit errors against its locally predicted sequence. It sits at the far end of the link or loopback, so the generator and checker together form a built-in bit-error-rate test.

## Interface
- LOCK_CNT, 4: consecutive error-free bytes required in VERIFY before declaring lock (legal 1..15).
- ERR_THR, 4: consecutive errored bytes in LOCKED that force loss of sync (legal 1..15).
- CNT_W, 16: width of the bit-error counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  8  received PRBS byte; bit 7 is the first bit in time.
- data_valid  in  1  data_in is sampled only when this is high.
- clr_cnt  in  1  synchronous clear of bit_err_cnt; has priority over increment.
- locked  out  1  high while in LOCKED.
- err_byte  out  1  one-cycle pulse: the last sampled byte in LOCKED had at least 1 bit error.
- err_bits  out  4  popcount of the last LOCKED byte mismatch, 0..8; 0 otherwise.
- sync_loss  out  1  one-cycle pulse on the LOCKED-to-SEARCH transition.
- bit_err_cnt  out  CNT_W  cumulative bit errors while locked; saturates at all-ones.

## Operation
- LFSR state s[14:0]. One step: b = s[14]^s[13]; s <= {s[13:0], b}. Predicted byte = 8 successive b values, MSB first; s advances 8 steps per valid byte.
- Seeding step uses the received bit r in place of b: s <= {s[13:0], r}.
- **SEARCH** (reset state)
  - Each valid byte is shifted in via seeding steps, bit 7 first; seed_cnt increments.
  - After the 2nd byte (16 bits), s equals the transmitter state.
  - If the resulting s != 0, go to VERIFY. If s == 0, stay in SEARCH with seed_cnt = 0; an all-zero stream must never lock.
- **VERIFY**
  - Each valid byte is compared with the predicted byte, and s advances from its own feedback.
  - Match: match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED.
  - Any mismatch: go to SEARCH and clear seed_cnt and match_cnt. That byte is discarded, not used as seed.
- **LOCKED**
  - s free-runs from its own feedback on each valid byte. Data is never reseeded, so errors do not propagate.
  - Mismatch: err_byte = 1, err_bits = popcount(data_in ^ predicted), bit_err_cnt += err_bits (saturating), consec_err++.
  - Match: consec_err = 0.
  - When consec_err reaches ERR_THR: pulse sync_loss, go to SEARCH, clear seed_cnt, match_cnt and consec_err. The errors of the triggering byte are still counted.
- **Counting rules**
  - Errors are counted only in LOCKED.
  - Saturation: the sum is computed CNT_W+1 wide and clamped to 2^CNT_W - 1.
  - clr_cnt in the same cycle as an errored byte: the counter becomes 0 and that byte's errors are dropped.
- data_valid low: no state change at all, and err_byte, err_bits and sync_loss are 0.
- Reset (asynchronous, mid-operation included): FSM = SEARCH; s, seed_cnt, match_cnt and consec_err = 0; all outputs 0.

## Timing
- All outputs are registered. err_byte, err_bits and sync_loss are valid in the cycle after the edge that samples the byte.
- Gapless clean stream: locked rises after the edge sampling byte 2+LOCK_CNT. With defaults this is the 6th valid byte.
- locked falls on the same edge that sets sync_loss.
- Throughput is one byte per cycle, with no back-pressure.

## Test plan
- **Clean lock:** generator seeded at 0x7FFF sends 0x00, 0x02, … continuously, with data_valid always high.
  - locked rises after the 6th byte.
  - err_byte stays 0 for 10,000 bytes; bit_err_cnt stays 0.
- **Single-bit errors:** while locked, XOR 0x01 into one byte, then 0xFF into a later byte.
  - err_bits = 1, then 8; bit_err_cnt = 1, then 9.
  - locked stays high throughout.
- **Lock loss:** while locked, corrupt 4 consecutive bytes with 0x80.
  - sync_loss pulses once and locked falls after the 4th byte; bit_err_cnt = 4.
  - Clean data then re-locks within 6 valid bytes.
- **All-zero and VERIFY failure:** drive 0x00 for 100 bytes, then send 2 seed bytes followed by a wrong 3rd byte.
  - locked never rises during the zero stream.
  - The wrong byte returns the FSM to SEARCH; the following clean stream locks.
- **Saturation and clear:** with CNT_W = 4, inject 0xFF errors.
  - The counter reaches 15 and holds.
  - clr_cnt together with an errored byte gives 0.
- **Gaps and reset:** toggle data_valid randomly.
  - The lock point counts valid bytes only.
  - Asserting rst low mid-LOCKED immediately zeroes all outputs; the checker re-locks after release.
